xhdmiin_wordalign: RTL and testbench



---
 rtl/xhdmiin_pkg.sv | 22 ++
 rtl/xhdmiin_ctrltoken.sv | 23 ++
 rtl/xhdmiin_wordalign.sv | 134 +++++++++++++
 tb/tb_xhdmiin_wordalign.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/xhdmiin_pkg.sv
// Shared TMDS definitions for the HDMI input channel blocks: control tokens,
// aligner state encoding and symbol width.
package xhdmiin_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  // Bit offsets sweep 0..9 and wrap.
  function automatic logic [3:0] next_shift(input logic [3:0] s);
    return (s == 4'd9) ? 4'd0 : s + 4'd1;
  endfunction

endpackage

// File: rtl/xhdmiin_ctrltoken.sv
// Combinational TMDS control-token detector: 10-bit symbol to {is_ctrl, C1C0}.
// ctrl is forced to 0 for any non-token symbol.
module xhdmiin_ctrltoken
  import xhdmiin_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctrl,
  output logic [1:0]       o_ctrl
);

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_sym)
      TOK_C00: o_ctrl = 2'b00;
      TOK_C01: o_ctrl = 2'b01;
      TOK_C10: o_ctrl = 2'b10;
      TOK_C11: o_ctrl = 2'b11;
      default: o_is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/xhdmiin_wordalign.sv
// TMDS word aligner: sweeps the ten bit offsets of the deserializer stream and
// locks where a run of control tokens decodes cleanly; pulses retry per failed sweep.
module xhdmiin_wordalign
  import xhdmiin_pkg::*;
#(
  parameter int LOCK_RUN  = 8,
  parameter int LGTIMEOUT = 20
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic [SYM_W-1:0] i_word,
  output logic [SYM_W-1:0] o_word,
  output logic             o_is_ctrl,
  output logic [1:0]       o_ctrl,
  output logic             o_locked,
  output logic [3:0]       o_shift,
  output logic             o_retry
);

  localparam logic [7:0] RUN_LAST = 8'(LOCK_RUN - 1);
  localparam logic [7:0] RUN_FULL = 8'(LOCK_RUN);

  align_state_e           state_q, state_d;
  logic [SYM_W-1:0]       prev_q;
  logic [3:0]             shift_q, shift_d;
  logic [7:0]             run_cnt_q, run_cnt_d, run_inc;
  logic [LGTIMEOUT-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                   retry_q, retry_d;
  logic [SYM_W-1:0]       word_q;
  logic                   is_ctrl_q;
  logic [1:0]             ctrl_q;

  logic [2*SYM_W-1:0]     window;
  logic [SYM_W-1:0]       cand_opt [10];
  logic [SYM_W-1:0]       cand;
  logic                   cand_is_ctrl;
  logic [1:0]             cand_ctrl;
  logic                   expire;
  logic                   run_full;

  // Shift 0 selects the previous word; higher shifts pull in low bits of the current one.
  assign window = {i_word, prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_cand
    assign cand_opt[gi] = window[gi +: SYM_W];
  end

  assign cand = cand_opt[shift_q];

  xhdmiin_ctrltoken u_ctrltoken (
    .i_sym     (cand),
    .o_is_ctrl (cand_is_ctrl),
    .o_ctrl    (cand_ctrl)
  );

  assign expire   = &tmo_cnt_q;
  // True on every token that leaves the run counter at LOCK_RUN.
  assign run_full = cand_is_ctrl && (run_cnt_q >= RUN_LAST);
  assign run_inc  = (run_cnt_q < RUN_FULL) ? run_cnt_q + 8'd1 : run_cnt_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    run_cnt_d = cand_is_ctrl ? run_inc : 8'd0;
    tmo_cnt_d = tmo_cnt_q + LGTIMEOUT'(1);
    retry_d   = 1'b0;

    if (!i_ce) begin
      state_d   = ST_SEARCH;
      shift_d   = 4'd0;
      run_cnt_d = 8'd0;
      tmo_cnt_d = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (run_full) begin
            state_d   = ST_LOCKED;
            tmo_cnt_d = '0;
          end else if (expire) begin
            run_cnt_d = 8'd0;
            tmo_cnt_d = '0;
            shift_d   = next_shift(shift_q);
            retry_d   = (shift_q == 4'd9);
          end
        end
        ST_LOCKED: begin
          // A completed run refreshes the watchdog and beats a same-cycle expiry.
          if (run_full) begin
            tmo_cnt_d = '0;
          end else if (expire) begin
            state_d   = ST_SEARCH;
            run_cnt_d = 8'd0;
            tmo_cnt_d = '0;
            shift_d   = next_shift(shift_q);
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_SEARCH;
      prev_q    <= '0;
      shift_q   <= 4'd0;
      run_cnt_q <= 8'd0;
      tmo_cnt_q <= '0;
      retry_q   <= 1'b0;
      word_q    <= '0;
      is_ctrl_q <= 1'b0;
      ctrl_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      prev_q    <= i_word;
      shift_q   <= shift_d;
      run_cnt_q <= run_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      retry_q   <= retry_d;
      word_q    <= cand;
      is_ctrl_q <= cand_is_ctrl;
      ctrl_q    <= cand_ctrl;
    end
  end

  assign o_word    = word_q;
  assign o_is_ctrl = is_ctrl_q;
  assign o_ctrl    = ctrl_q;
  assign o_locked  = (state_q == ST_LOCKED);
  assign o_shift   = shift_q;
  assign o_retry   = retry_q;

endmodule

// File: tb/tb_xhdmiin_wordalign.sv
// Directed bench for the TMDS word aligner (LOCK_RUN=8, LGTIMEOUT=8):
// reset, offset-0 lock, skewed lock, sweep/retry, lock timeout and clears.
module tb_xhdmiin_wordalign;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_ce = 1'b0;
  logic [9:0] i_word = 10'd0;
  logic [9:0] o_word;
  logic       o_is_ctrl;
  logic [1:0] o_ctrl;
  logic       o_locked;
  logic [3:0] o_shift;
  logic       o_retry;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  xhdmiin_wordalign #(
    .LOCK_RUN  (8),
    .LGTIMEOUT (8)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_word    (i_word),
    .o_word    (o_word),
    .o_is_ctrl (o_is_ctrl),
    .o_ctrl    (o_ctrl),
    .o_locked  (o_locked),
    .o_shift   (o_shift),
    .o_retry   (o_retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word, then land 1 time unit after the next rising edge.
  task automatic tick(input logic [9:0] w);
    i_word = w;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [9:0] tok;
    logic [9:0] w3;
    logic [9:0] w5;
    int first1;
    int lock_at;
    int retries;
    int locks;
    int errs;
    int exp_shift;
    logic exp_retry;

    // Reset held with random data on the input
    i_reset_n = 1'b0;
    i_ce      = 1'b1;
    for (int k = 0; k < 4; k++) tick(10'($urandom_range(1023, 0)));
    chk("rst_word", o_word, 0);
    chk("rst_is_ctrl", o_is_ctrl, 0);
    chk("rst_ctrl", o_ctrl, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_shift", o_shift, 0);
    chk("rst_retry", o_retry, 0);

    // 0x354 stream at offset 0: first output is the reset-cleared previous word
    i_reset_n = 1'b1;
    tick(10'h354);
    chk("lock0_first_is_ctrl", o_is_ctrl, 0);
    for (int k = 2; k <= 8; k++) tick(10'h354);
    chk("lock0_word_7th", o_word, 10'h354);
    chk("lock0_not_yet", o_locked, 0);
    tick(10'h354);
    chk("lock0_locked", o_locked, 1);
    chk("lock0_shift", o_shift, 0);
    chk("lock0_ctrl", o_ctrl, 0);
    chk("lock0_is_ctrl", o_is_ctrl, 1);
    chk("lock0_word", o_word, 10'h354);

    // Asynchronous reset pulse in the middle of a cycle
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("areset_locked", o_locked, 0);
    chk("areset_word", o_word, 0);
    chk("areset_is_ctrl", o_is_ctrl, 0);
    #1;
    i_reset_n = 1'b1;

    // 0x2AB skewed so that it frames at offset 3
    tok = 10'h2AB;
    w3  = {tok[6:0], tok[9:7]};
    i_ce = 1'b0;
    tick(w3);
    chk("skew_clear_shift", o_shift, 0);
    i_ce = 1'b1;
    first1 = -1; lock_at = -1; retries = 0;
    for (int k = 1; k <= 2000 && lock_at < 0; k++) begin
      tick(w3);
      if (o_retry) retries++;
      if (first1 < 0 && o_shift == 4'd1) first1 = k;
      if (o_locked) lock_at = k;
    end
    chk("skew_first_advance", first1, 256);
    chk("skew_lock_edge", lock_at, 776);
    chk("skew_shift", o_shift, 3);
    chk("skew_word", o_word, 10'h2AB);
    chk("skew_ctrl", o_ctrl, 3);
    chk("skew_is_ctrl", o_is_ctrl, 1);
    chk("skew_no_retry", retries, 0);

    // One cycle of channel disable while locked
    i_ce = 1'b0;
    tick(w3);
    chk("ce_locked", o_locked, 0);
    chk("ce_shift", o_shift, 0);
    chk("ce_retry", o_retry, 0);
    chk("ce_word_live", o_word, 10'h2AB);
    i_ce = 1'b1;

    // Random data: full sweeps, one retry per 2560 cycles, never locked
    errs = 0; retries = 0; locks = 0;
    for (int k = 1; k <= 5200; k++) begin
      tick(10'($urandom_range(1023, 0)));
      exp_shift = (k / 256) % 10;
      exp_retry = ((k % 2560) == 0);
      if (o_shift !== 4'(exp_shift) || o_retry !== exp_retry) errs++;
      if (o_retry) retries++;
      if (o_locked) locks++;
    end
    chk("sweep_shift_retry_errs", errs, 0);
    chk("sweep_retry_count", retries, 2);
    chk("sweep_never_locked", locks, 0);

    // Lock at offset 5 with 0x354
    tok = 10'h354;
    w5  = {tok[4:0], tok[9:5]};
    i_ce = 1'b0;
    tick(w5);
    i_ce = 1'b1;
    lock_at = -1; retries = 0;
    for (int k = 1; k <= 2000 && lock_at < 0; k++) begin
      tick(w5);
      if (o_retry) retries++;
      if (o_locked) lock_at = k;
    end
    chk("s5_lock_edge", lock_at, 1288);
    chk("s5_shift", o_shift, 5);
    chk("s5_no_retry", retries, 0);

    // Token run completing exactly on the expiry cycle keeps lock
    for (int k = 0; k < 247; k++) tick(10'h000);
    for (int k = 0; k < 9; k++) tick(w5);
    chk("race_keep_locked", o_locked, 1);
    chk("race_word", o_word, 10'h354);

    // No further run: lock held for 255 cycles, lost on the 256th
    retries = 0;
    for (int k = 0; k < 255; k++) begin
      tick(10'h000);
      if (o_retry) retries++;
    end
    chk("tmo_hold_locked", o_locked, 1);
    tick(10'h000);
    if (o_retry) retries++;
    chk("tmo_unlocked", o_locked, 0);
    chk("tmo_shift", o_shift, 6);
    chk("tmo_no_retry", retries, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
